// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, control bundle widths and ALUOp encodings.
// The control decode lives here so every stage agrees on bundle bit positions.
package mips_pkg;

    localparam int WB_W = 2;
    localparam int M_W  = 3;
    localparam int EX_W = 4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // wb = {RegWrite, MemtoReg}, m = {Branch, MemRead, MemWrite}, ex = {RegDst, ALUOp, ALUSrc}
    typedef struct packed {
        logic [WB_W-1:0] wb;
        logic [M_W-1:0]  m;
        logic [EX_W-1:0] ex;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
        ctrl_t c;
        c = '0;
        case (opcode)
            OP_RTYPE: begin
                c.wb = 2'b10;
                c.m  = 3'b000;
                c.ex = {1'b1, ALUOP_FUNCT, 1'b0};
            end
            OP_LW: begin
                c.wb = 2'b11;
                c.m  = 3'b010;
                c.ex = {1'b0, ALUOP_ADD, 1'b1};
            end
            OP_SW: begin
                c.wb = 2'b00;
                c.m  = 3'b001;
                c.ex = {1'b0, ALUOP_ADD, 1'b1};
            end
            OP_BEQ: begin
                c.wb = 2'b00;
                c.m  = 3'b100;
                c.ex = {1'b0, ALUOP_SUB, 1'b0};
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/idecode_register.sv
// 32-entry register file: two async read ports, one sync write port, r0 hardwired to zero.
// A write landing on the same edge as a read is forwarded so decode sees the committing value.
module register #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RA_W-1:0]   rs_addr,
    input  logic [RA_W-1:0]   rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              we,
    input  logic [RA_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int NREG = 1 << RA_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic              wr_en;

    assign wr_en = we && (wr_addr != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[wr_addr] = wr_data;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rs_data = regs_q[rs_addr];
        if (wr_en && (wr_addr == rs_addr)) begin
            rs_data = wr_data;
        end
        if (rs_addr == '0) begin
            rs_data = '0;
        end
    end

    always_comb begin
        rt_data = regs_q[rt_addr];
        if (wr_en && (wr_addr == rt_addr)) begin
            rt_data = wr_data;
        end
        if (rt_addr == '0) begin
            rt_data = '0;
        end
    end

endmodule

// File: rtl/idecode.sv
// MIPS instruction-decode stage: control decode, register read, sign-extend, ID/EX latch.
// A taken branch downstream turns the next latched control into a bubble; data still loads.
module idecode
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       IF_ID_instr,
    input  logic [31:0]       IF_ID_npc,
    input  logic              EX_MEM_PCSrc,
    input  logic              MEM_WB_RegWrite,
    input  logic [RA_W-1:0]   MEM_WB_Writereg,
    input  logic [DATA_W-1:0] WB_writedata,
    output logic [1:0]        ID_EX_wb,
    output logic [2:0]        ID_EX_m,
    output logic [3:0]        ID_EX_ex,
    output logic [DATA_W-1:0] ID_EX_npc,
    output logic [DATA_W-1:0] ID_EX_readdat1,
    output logic [DATA_W-1:0] ID_EX_readdat2,
    output logic [DATA_W-1:0] ID_EX_sign_ext,
    output logic [RA_W-1:0]   ID_EX_instr_2016,
    output logic [RA_W-1:0]   ID_EX_instr_1511
);

    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;

    ctrl_t             ctrl_d,      ctrl_q;
    logic [DATA_W-1:0] npc_d,       npc_q;
    logic [DATA_W-1:0] readdat1_d,  readdat1_q;
    logic [DATA_W-1:0] readdat2_d,  readdat2_q;
    logic [DATA_W-1:0] sign_ext_d,  sign_ext_q;
    logic [RA_W-1:0]   rt_field_d,  rt_field_q;
    logic [RA_W-1:0]   rd_field_d,  rd_field_q;

    register #(
        .DATA_W (DATA_W),
        .RA_W   (RA_W)
    ) u_register (
        .clk     (clk),
        .rst     (rst),
        .rs_addr (IF_ID_instr[25:21]),
        .rt_addr (IF_ID_instr[20:16]),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .we      (MEM_WB_RegWrite),
        .wr_addr (MEM_WB_Writereg),
        .wr_data (WB_writedata)
    );

    always_comb begin
        ctrl_d = decode_ctrl(IF_ID_instr[31:26]);
        if (EX_MEM_PCSrc) begin
            ctrl_d = '0;
        end
        npc_d      = IF_ID_npc;
        readdat1_d = rs_data;
        readdat2_d = rt_data;
        sign_ext_d = {{(DATA_W-16){IF_ID_instr[15]}}, IF_ID_instr[15:0]};
        rt_field_d = IF_ID_instr[20:16];
        rd_field_d = IF_ID_instr[15:11];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q     <= '0;
            npc_q      <= '0;
            readdat1_q <= '0;
            readdat2_q <= '0;
            sign_ext_q <= '0;
            rt_field_q <= '0;
            rd_field_q <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            npc_q      <= npc_d;
            readdat1_q <= readdat1_d;
            readdat2_q <= readdat2_d;
            sign_ext_q <= sign_ext_d;
            rt_field_q <= rt_field_d;
            rd_field_q <= rd_field_d;
        end
    end

    assign ID_EX_wb         = ctrl_q.wb;
    assign ID_EX_m          = ctrl_q.m;
    assign ID_EX_ex         = ctrl_q.ex;
    assign ID_EX_npc        = npc_q;
    assign ID_EX_readdat1   = readdat1_q;
    assign ID_EX_readdat2   = readdat2_q;
    assign ID_EX_sign_ext   = sign_ext_q;
    assign ID_EX_instr_2016 = rt_field_q;
    assign ID_EX_instr_1511 = rd_field_q;

endmodule

// File: tb/tb_idecode.sv
// Directed bench for idecode: reset, write-back/read, bypass, r0 protection, flush, decode table.
module tb_idecode;

    logic        clk;
    logic        rst;
    logic [31:0] IF_ID_instr;
    logic [31:0] IF_ID_npc;
    logic        EX_MEM_PCSrc;
    logic        MEM_WB_RegWrite;
    logic [4:0]  MEM_WB_Writereg;
    logic [31:0] WB_writedata;
    logic [1:0]  ID_EX_wb;
    logic [2:0]  ID_EX_m;
    logic [3:0]  ID_EX_ex;
    logic [31:0] ID_EX_npc;
    logic [31:0] ID_EX_readdat1;
    logic [31:0] ID_EX_readdat2;
    logic [31:0] ID_EX_sign_ext;
    logic [4:0]  ID_EX_instr_2016;
    logic [4:0]  ID_EX_instr_1511;

    int n_checks = 0;
    int n_errors = 0;

    idecode dut (
        .clk              (clk),
        .rst              (rst),
        .IF_ID_instr      (IF_ID_instr),
        .IF_ID_npc        (IF_ID_npc),
        .EX_MEM_PCSrc     (EX_MEM_PCSrc),
        .MEM_WB_RegWrite  (MEM_WB_RegWrite),
        .MEM_WB_Writereg  (MEM_WB_Writereg),
        .WB_writedata     (WB_writedata),
        .ID_EX_wb         (ID_EX_wb),
        .ID_EX_m          (ID_EX_m),
        .ID_EX_ex         (ID_EX_ex),
        .ID_EX_npc        (ID_EX_npc),
        .ID_EX_readdat1   (ID_EX_readdat1),
        .ID_EX_readdat2   (ID_EX_readdat2),
        .ID_EX_sign_ext   (ID_EX_sign_ext),
        .ID_EX_instr_2016 (ID_EX_instr_2016),
        .ID_EX_instr_1511 (ID_EX_instr_1511)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".wb"},   {30'd0, ID_EX_wb}, 32'd0);
        check({tag, ".m"},    {29'd0, ID_EX_m}, 32'd0);
        check({tag, ".ex"},   {28'd0, ID_EX_ex}, 32'd0);
        check({tag, ".npc"},  ID_EX_npc, 32'd0);
        check({tag, ".rd1"},  ID_EX_readdat1, 32'd0);
        check({tag, ".rd2"},  ID_EX_readdat2, 32'd0);
        check({tag, ".sext"}, ID_EX_sign_ext, 32'd0);
        check({tag, ".rt"},   {27'd0, ID_EX_instr_2016}, 32'd0);
        check({tag, ".rd"},   {27'd0, ID_EX_instr_1511}, 32'd0);
    endtask

    task automatic check_ctrl(input string tag, input logic [1:0] wb, input logic [2:0] m,
                              input logic [3:0] ex);
        check({tag, ".wb"}, {30'd0, ID_EX_wb}, {30'd0, wb});
        check({tag, ".m"},  {29'd0, ID_EX_m},  {29'd0, m});
        check({tag, ".ex"}, {28'd0, ID_EX_ex}, {28'd0, ex});
    endtask

    // driver: called at a negedge, applies one cycle of inputs, returns at the next negedge
    task automatic drive(input logic [31:0] instr, input logic [31:0] npc, input logic pcsrc,
                         input logic rw, input logic [4:0] wreg, input logic [31:0] wdata);
        IF_ID_instr     = instr;
        IF_ID_npc       = npc;
        EX_MEM_PCSrc    = pcsrc;
        MEM_WB_RegWrite = rw;
        MEM_WB_Writereg = wreg;
        WB_writedata    = wdata;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst             = 1'b1;
        IF_ID_instr     = 32'h0;
        IF_ID_npc       = 32'h0;
        EX_MEM_PCSrc    = 1'b0;
        MEM_WB_RegWrite = 1'b0;
        MEM_WB_Writereg = 5'd0;
        WB_writedata    = 32'h0;

        @(negedge clk);
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // write r8 = 0xAA, then decode add $t1,$t0,$t0
        drive(32'h0000_0000, 32'h100, 1'b0, 1'b1, 5'd8, 32'h0000_00AA);
        drive(32'h0108_4820, 32'h104, 1'b0, 1'b0, 5'd0, 32'h0);
        check("add.rd1", ID_EX_readdat1, 32'hAA);
        check("add.rd2", ID_EX_readdat2, 32'hAA);
        check_ctrl("add", 2'b10, 3'b000, 4'b1100);
        check("add.rd_field", {27'd0, ID_EX_instr_1511}, 32'd9);
        check("add.rt_field", {27'd0, ID_EX_instr_2016}, 32'd8);
        check("add.npc", ID_EX_npc, 32'h104);
        check("add.sext", ID_EX_sign_ext, 32'h0000_4820);

        // same-cycle write r3 and decode lw $4,-4($3)
        drive(32'h8C64_FFFC, 32'h108, 1'b0, 1'b1, 5'd3, 32'hDEAD_BEEF);
        check("lw.rd1_bypass", ID_EX_readdat1, 32'hDEAD_BEEF);
        check("lw.rd2", ID_EX_readdat2, 32'h0);
        check("lw.sext", ID_EX_sign_ext, 32'hFFFF_FFFC);
        check_ctrl("lw", 2'b11, 3'b010, 4'b0001);
        check("lw.rt_field", {27'd0, ID_EX_instr_2016}, 32'd4);

        // r3 was committed by the bypassed write
        drive(32'h0068_4820, 32'h10C, 1'b0, 1'b0, 5'd0, 32'h0);
        check("r3_stored.rd1", ID_EX_readdat1, 32'hDEAD_BEEF);
        check("r3_stored.rd2", ID_EX_readdat2, 32'hAA);

        // r0 write is discarded, even when read in the same cycle
        drive(32'h0000_0000, 32'h110, 1'b0, 1'b1, 5'd0, 32'h0000_1234);
        check("r0_same.rd1", ID_EX_readdat1, 32'h0);
        check("r0_same.rd2", ID_EX_readdat2, 32'h0);
        drive(32'h0000_0000, 32'h114, 1'b0, 1'b1, 5'd5, 32'h0000_0055);
        check("r0_later.rd1", ID_EX_readdat1, 32'h0);
        check("r0_later.rd2", ID_EX_readdat2, 32'h0);
        check_ctrl("nop", 2'b10, 3'b000, 4'b1100);

        // flushed beq, with a write-back of r1 still committing
        drive(32'h1022_0003, 32'h118, 1'b1, 1'b1, 5'd1, 32'h0000_0011);
        check_ctrl("flush", 2'b00, 3'b000, 4'b0000);
        check("flush.npc", ID_EX_npc, 32'h118);
        check("flush.rd1", ID_EX_readdat1, 32'h11);
        check("flush.rd2", ID_EX_readdat2, 32'h0);
        check("flush.sext", ID_EX_sign_ext, 32'h3);

        drive(32'h1022_0003, 32'h11C, 1'b0, 1'b0, 5'd0, 32'h0);
        check_ctrl("beq", 2'b00, 3'b100, 4'b0010);
        check("beq.rd1", ID_EX_readdat1, 32'h11);

        // unknown opcode 0x3F with negative immediate
        drive(32'hFC6A_8000, 32'h120, 1'b0, 1'b0, 5'd0, 32'h0);
        check_ctrl("unk", 2'b00, 3'b000, 4'b0000);
        check("unk.sext", ID_EX_sign_ext, 32'hFFFF_8000);
        check("unk.rd1", ID_EX_readdat1, 32'hDEAD_BEEF);
        check("unk.rt_field", {27'd0, ID_EX_instr_2016}, 32'd10);

        // sw $5,16($2)
        drive(32'hAC45_0010, 32'h124, 1'b0, 1'b0, 5'd0, 32'h0);
        check_ctrl("sw", 2'b00, 3'b001, 4'b0001);
        check("sw.sext", ID_EX_sign_ext, 32'h10);
        check("sw.rd2", ID_EX_readdat2, 32'h55);
        check("sw.rt_field", {27'd0, ID_EX_instr_2016}, 32'd5);

        // mid-run asynchronous reset
        drive(32'h0065_2820, 32'h128, 1'b0, 1'b0, 5'd0, 32'h0);
        check("pre_rst.rd2", ID_EX_readdat2, 32'h55);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #1;
        check_all_zero("rst_held");
        @(negedge clk);
        rst = 1'b0;
        drive(32'h0065_2820, 32'h12C, 1'b0, 1'b0, 5'd0, 32'h0);
        check("post_rst.r3", ID_EX_readdat1, 32'h0);
        check("post_rst.r5", ID_EX_readdat2, 32'h0);
        check_ctrl("post_rst", 2'b10, 3'b000, 4'b1100);
        check("post_rst.npc", ID_EX_npc, 32'h12C);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
